// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the two-digit BCD stopwatch.
package stopwatch_pkg;

    // Control states; the unused encoding 2'd3 is decoded as IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // Highest legal value of a single BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : stopwatch_pkg

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// Single mod-10 BCD digit with synchronous clear and a carry-out
// that fires on the increment that rolls 9 back to 0.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q, q_d;

    // Next digit value: clear has priority, then increment modulo 10.
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc) begin
            // >= keeps the digit inside 0-9 even from an illegal value.
            q_d = (q_q >= BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    // Digit register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == BCD_MAX);

endmodule : bcd_digit

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detect, IDLE/RUN/PAUSE control,
// prescaler gating, cascaded ones/tens BCD count, lap freeze and the
// display mux feeding the 7-segment driver.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       btn_lap,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic       running,
    output logic       lap_held,
    output logic       wrap
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    // Button history for rising-edge detection.
    logic ss_q, clr_q, lap_q;
    logic ss_ev, clr_ev, lap_ev;

    // Control state.
    state_e state_q, state_d;
    logic   in_run;
    logic   clr_act;

    // Prescaler and count.
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [3:0]    ones_q, tens_q;
    logic          ones_carry, tens_carry;

    // Lap capture and registered outputs.
    logic       lap_held_q, lap_held_d;
    logic [3:0] lap_ones_q, lap_ones_d;
    logic [3:0] lap_tens_q, lap_tens_d;
    logic       running_q, running_d;
    logic       wrap_q, wrap_d;

    assign ss_ev  = btn_ss  & ~ss_q;
    assign clr_ev = btn_clr & ~clr_q;
    assign lap_ev = btn_lap & ~lap_q;

    assign in_run = (state_q == RUN);
    // Clear is only honoured while stopped; in RUN it is dropped.
    assign clr_act = clr_ev & ~in_run;
    // A tick is the RUN edge where the prescaler completes its period.
    assign tick    = in_run & (presc_q == PRESC_LAST);

    // Record last-cycle button levels so a held button yields one event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_q  <= 1'b0;
            clr_q <= 1'b0;
            lap_q <= 1'b0;
        end else begin
            ss_q  <= btn_ss;
            clr_q <= btn_clr;
            lap_q <= btn_lap;
        end
    end

    // Next control state; clear beats start/stop when both arrive together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (ss_ev) state_d = PAUSE;
            end
            PAUSE: begin
                if (clr_ev)     state_d = IDLE;
                else if (ss_ev) state_d = RUN;
            end
            default: begin
                state_d = IDLE;
                if (!clr_ev && ss_ev) state_d = RUN;
            end
        endcase
    end

    // Prescaler advances only in RUN, wraps on a tick, holds in PAUSE.
    always_comb begin
        presc_d = presc_q;
        if (clr_act) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else if (in_run) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Lap freeze: capture in RUN when free, release on any lap event while held.
    always_comb begin
        lap_held_d = lap_held_q;
        lap_ones_d = lap_ones_q;
        lap_tens_d = lap_tens_q;
        if (clr_act) begin
            lap_held_d = 1'b0;
        end else if (lap_ev) begin
            if (lap_held_q) begin
                lap_held_d = 1'b0;
            end else if (in_run) begin
                lap_held_d = 1'b1;
                lap_ones_d = ones_q;
                lap_tens_d = tens_q;
            end
        end
    end

    // Status flags registered alongside the state they describe.
    always_comb begin
        running_d = (state_d == RUN);
        wrap_d    = tens_carry;
    end

    // Control, prescaler, lap and status registers.
    // NOTE: the lap capture digits are reset too, so no value from before reset can ever reach the display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            lap_held_q <= 1'b0;
            lap_ones_q <= 4'd0;
            lap_tens_q <= 4'd0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            lap_held_q <= lap_held_d;
            lap_ones_q <= lap_ones_d;
            lap_tens_q <= lap_tens_d;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
        end
    end

    bcd_digit u_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_act),
        .inc   (tick),
        .q     (ones_q),
        .carry (ones_carry)
    );

    bcd_digit u_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_act),
        .inc   (ones_carry),
        .q     (tens_q),
        .carry (tens_carry)
    );

    assign disp_ones = lap_held_q ? lap_ones_q : ones_q;
    assign disp_tens = lap_held_q ? lap_tens_q : tens_q;
    assign running   = running_q;
    assign lap_held  = lap_held_q;
    assign wrap      = wrap_q;

endmodule : stopwatch_ctrl
